// File: rtl/dcnn_io_pkg.sv
// Shared types and default sizes for the DCNN IO loading path.
//   loader_state_t : sequencing states of multi_bank_loader
//   *_WORDS        : default bank lengths in words (CNN weights, FC weights, image)
//   DATA_W_DEF     : default stream / RAM word width
//   ADDR_W_DEF     : default bank-local RAM address width
package dcnn_io_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        LOAD = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } loader_state_t;

    localparam int unsigned CNN_WORDS  = 50704;
    localparam int unsigned FC_WORDS   = 11218;
    localparam int unsigned IMG_WORDS  = 1024;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    // Width of a channel index; kept at least 1 so a single-bank build still elaborates.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loader_addr_ctr.sv
// Bank-local word address counter for multi_bank_loader.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous clear to address 0 (wins over en_i)
//   en_i   : advance by one word
//   len_i  : current bank length in words (non-zero whenever en_i can be high)
//   addr_o : current word address
//   last_o : addr_o is the final word of the bank (len_i - 1)
module loader_addr_ctr #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_o = (addr_q == (len_i - ADDR_W'(1)));
    assign addr_o = addr_q;

    // Holds at the last address instead of stepping past it, so a full 2**ADDR_W bank never
    // wraps back to 0.
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (en_i && !last_o) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/multi_bank_loader.sv
// Streams a single valid/ready word stream into N_CH RAM banks, bank 0 first, over one
// shared registered write bus. Reports per-bank and overall completion.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : pulse, begin a full load sequence (ignored while busy)
//   abort    : pulse, cancel the load in progress (wins over start)
//   in_valid : stream word valid
//   in_data  : stream word
//   in_ready : loader accepts in_data this cycle
//   wr_en    : RAM write strobe
//   wr_sel   : one-hot bank select, valid with wr_en
//   wr_addr  : bank-local word address
//   wr_data  : write data
//   busy     : sequence in progress
//   done     : all banks loaded; held until next start or rst
//   ch_done  : per-bank completion, sticky until next start or rst
module multi_bank_loader
    import dcnn_io_pkg::*;
#(
    parameter int unsigned             DATA_W = DATA_W_DEF,
    parameter int unsigned             ADDR_W = ADDR_W_DEF,
    parameter int unsigned             N_CH   = 3,
    parameter logic [N_CH*ADDR_W-1:0]  CH_LEN = {16'(IMG_WORDS), 16'(FC_WORDS), 16'(CNN_WORDS)}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [N_CH-1:0]   wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   ch_done
);

    localparam int unsigned       CH_W    = ch_idx_w(N_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    // A length field is ADDR_W bits wide, so this only fires if the field layout is changed.
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_len_chk
        if (64'(CH_LEN[i*ADDR_W +: ADDR_W]) > (64'd1 << ADDR_W)) begin : g_err
            $error("multi_bank_loader: bank %0d length exceeds 2**ADDR_W", i);
        end
    end

    loader_state_t      state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [N_CH-1:0]    ch_done_q, ch_done_d;
    logic               wr_en_q, wr_en_d;
    logic [N_CH-1:0]    wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [ADDR_W-1:0]  len_cur;
    logic [ADDR_W-1:0]  ctr_addr;
    logic               ctr_last;
    logic               ctr_clr;
    logic               accept;

    // Length of the bank currently selected.
    always_comb begin
        len_cur = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == CH_W'(i)) begin
                len_cur = CH_LEN[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && (state_q == LOAD);
    assign busy     = (state_q == SEL) || (state_q == LOAD) || (state_q == NEXT);
    assign done     = (state_q == DONE);

    // Counter sits at 0 outside LOAD, so every bank starts from address 0.
    assign ctr_clr  = (state_q != LOAD);

    loader_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (ctr_clr),
        .en_i   (accept),
        .len_i  (len_cur),
        .addr_o (ctr_addr),
        .last_o (ctr_last)
    );

    // Sequencing FSM.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        ch_done_d = ch_done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_d   = SEL;
                    ch_d      = '0;
                    ch_done_d = '0;
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (len_cur == '0) begin
                    // Empty bank: complete it without ever touching the write bus.
                    ch_done_d[ch_q] = 1'b1;
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && ctr_last) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // The bank's last word is already on the write bus, so it counts as complete
                // even if this cycle is aborted.
                ch_done_d[ch_q] = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = SEL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write bus register: one-cycle latency; select/address/data hold between writes.
    always_comb begin
        wr_en_d   = accept;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_sel_d  = N_CH'(1) << ch_q;
            wr_addr_d = ctr_addr;
            wr_data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            ch_done_q <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ch_done_q <= ch_done_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign ch_done = ch_done_q;

endmodule

// File: tb/tb_multi_bank_loader.sv
// Bench for multi_bank_loader: scoreboarded stream into a {4,3,5} instance, a {2,0,2}
// instance with an empty middle bank, and a default-length instance for the long bank.
module tb_multi_bank_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance A: bank lengths 4,3,5
    logic        a_start = 0, a_abort = 0, a_in_valid = 0;
    logic [15:0] a_in_data = 0;
    logic        a_in_ready, a_wr_en, a_busy, a_done;
    logic [2:0]  a_wr_sel, a_ch_done;
    logic [15:0] a_wr_addr, a_wr_data;

    multi_bank_loader #(
        .DATA_W (16), .ADDR_W (16), .N_CH (3), .CH_LEN ({16'd5, 16'd3, 16'd4})
    ) dut_a (
        .clk (clk), .rst (rst), .start (a_start), .abort (a_abort),
        .in_valid (a_in_valid), .in_data (a_in_data), .in_ready (a_in_ready),
        .wr_en (a_wr_en), .wr_sel (a_wr_sel), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
        .busy (a_busy), .done (a_done), .ch_done (a_ch_done)
    );

    // Instance Z: empty middle bank
    logic        z_start = 0, z_abort = 0, z_in_valid = 0;
    logic [15:0] z_in_data = 0;
    logic        z_in_ready, z_wr_en, z_busy, z_done;
    logic [2:0]  z_wr_sel, z_ch_done;
    logic [15:0] z_wr_addr, z_wr_data;

    multi_bank_loader #(
        .DATA_W (16), .ADDR_W (16), .N_CH (3), .CH_LEN ({16'd2, 16'd0, 16'd2})
    ) dut_z (
        .clk (clk), .rst (rst), .start (z_start), .abort (z_abort),
        .in_valid (z_in_valid), .in_data (z_in_data), .in_ready (z_in_ready),
        .wr_en (z_wr_en), .wr_sel (z_wr_sel), .wr_addr (z_wr_addr), .wr_data (z_wr_data),
        .busy (z_busy), .done (z_done), .ch_done (z_ch_done)
    );

    // Instance D: default lengths (bank 0 = 50704 words)
    logic        d_start = 0, d_abort = 0, d_in_valid = 0;
    logic [15:0] d_in_data = 0;
    logic        d_in_ready, d_wr_en, d_busy, d_done;
    logic [2:0]  d_wr_sel, d_ch_done;
    logic [15:0] d_wr_addr, d_wr_data;

    multi_bank_loader dut_d (
        .clk (clk), .rst (rst), .start (d_start), .abort (d_abort),
        .in_valid (d_in_valid), .in_data (d_in_data), .in_ready (d_in_ready),
        .wr_en (d_wr_en), .wr_sel (d_wr_sel), .wr_addr (d_wr_addr), .wr_data (d_wr_data),
        .busy (d_busy), .done (d_done), .ch_done (d_ch_done)
    );

    // Scoreboard for instance A: {sel, addr, data} pushed on acceptance.
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    int          a_wr_n    = 0;
    int          a_len[3]  = '{4, 3, 5};
    int          word_base = 0;

    task automatic mon_a();
        if (a_wr_en) begin
            a_wr_n++;
            if (exp_q.size() == 0) begin
                check_eq("a_unexp_wr", 64'(a_wr_en), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("a_wr", 64'({a_wr_sel, a_wr_addr, a_wr_data}), 64'(mon_e));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon_a();
    endtask

    task automatic start_a();
        tick(); a_start = 1'b1;
        tick(); a_start = 1'b0;
    endtask

    task automatic run_a(input int total, input bit stall, input int abort_at,
                         input int start_at, output int bubbles);
        int sent = 0, cyc = 0, m_ch = 0, m_addr = 0;
        bubbles = 0;
        while (sent < total && cyc < 500) begin
            tick();
            a_start    = 1'b0;
            a_abort    = 1'b0;
            a_in_valid = stall ? (cyc % 2 == 1) : 1'b1;
            a_in_data  = 16'(word_base + sent);
            if (a_in_valid && !a_in_ready) bubbles++;
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back({3'(1 << m_ch), 16'(m_addr), a_in_data});
                sent++;
                m_addr++;
                if (m_addr == a_len[m_ch]) begin
                    m_addr = 0;
                    m_ch++;
                end
                if (sent == abort_at) a_abort = 1'b1;
                if (sent == start_at) a_start = 1'b1;
            end
            cyc++;
        end
        if (sent < total) check_eq("a_stream_timeout", 64'(sent), 64'(total));
        tick();
        a_in_valid = 1'b0;
        a_start    = 1'b0;
        a_abort    = 1'b0;
    endtask

    task automatic wait_a_done();
        for (int i = 0; i < 20 && !a_done; i++) tick();
        check_eq("a_done", 64'(a_done), 64'd1);
        check_eq("a_ch_done", 64'(a_ch_done), 64'd7);
        check_eq("a_busy_done", 64'(a_busy), 64'd0);
        check_eq("a_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, wr0, z_n, z_acc, d_n;
        bit d_hit;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check_eq("rst_outs", 64'({a_in_ready, a_wr_en, a_wr_sel, a_wr_addr, a_wr_data,
                                  a_busy, a_done, a_ch_done}), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Full load, in_valid always high
        word_base = 16'h0100; wr0 = a_wr_n;
        start_a();
        check_eq("a_busy_sel", 64'(a_busy), 64'd1);
        run_a(12, 1'b0, -1, -1, b);
        check_eq("a_bubbles", 64'(b), 64'd4);
        wait_a_done();
        check_eq("a_wr_cnt_full", 64'(a_wr_n - wr0), 64'd12);

        // Stalled stream; restart from DONE clears completion
        word_base = 16'h0200; wr0 = a_wr_n;
        start_a();
        check_eq("a_restart_ch_done", 64'({a_done, a_ch_done}), 64'd0);
        run_a(12, 1'b1, -1, -1, b);
        wait_a_done();
        check_eq("a_wr_cnt_stall", 64'(a_wr_n - wr0), 64'd12);

        // Abort after the 2nd word of bank 1
        word_base = 16'h0300; wr0 = a_wr_n;
        start_a();
        run_a(6, 1'b0, 6, -1, b);
        tick(); tick();
        check_eq("abort_busy", 64'(a_busy), 64'd0);
        check_eq("abort_done", 64'(a_done), 64'd0);
        check_eq("abort_ch_done", 64'(a_ch_done), 64'd1);
        check_eq("abort_wr_cnt", 64'(a_wr_n - wr0), 64'd6);
        check_eq("abort_q_empty", 64'(exp_q.size()), 64'd0);
        word_base = 16'h0400; wr0 = a_wr_n;
        start_a();
        check_eq("reload_ch_done", 64'(a_ch_done), 64'd0);
        run_a(12, 1'b0, -1, -1, b);
        wait_a_done();
        check_eq("reload_wr_cnt", 64'(a_wr_n - wr0), 64'd12);

        // start during LOAD of bank 1 is ignored
        word_base = 16'h0500; wr0 = a_wr_n;
        start_a();
        run_a(12, 1'b0, -1, 7, b);
        wait_a_done();
        check_eq("start_busy_wr_cnt", 64'(a_wr_n - wr0), 64'd12);

        // rst mid-LOAD of bank 1
        word_base = 16'h0600; wr0 = a_wr_n;
        start_a();
        run_a(6, 1'b0, -1, -1, b);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_outs", 64'({a_in_ready, a_wr_en, a_wr_sel, a_wr_addr, a_wr_data,
                                      a_busy, a_done, a_ch_done}), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_mid_wr_cnt", 64'(a_wr_n - wr0), 64'd6);
        check_eq("rst_mid_idle", 64'({a_busy, a_done, a_in_ready}), 64'd0);

        // start and abort together from IDLE: abort wins
        a_start = 1'b1; a_abort = 1'b1;
        tick();
        a_start = 1'b0; a_abort = 1'b0;
        tick();
        check_eq("start_abort_idle", 64'({a_busy, a_in_ready}), 64'd0);

        // Zero-length middle bank
        @(negedge clk); z_start = 1'b1;
        @(negedge clk); z_start = 1'b0; z_in_valid = 1'b1;
        z_n = 0; z_acc = 0;
        for (int c = 0; c < 60 && !z_done; c++) begin
            @(negedge clk);
            if (z_wr_en) begin
                check_eq("z_sel", 64'(z_wr_sel), (z_n < 2) ? 64'd1 : 64'd4);
                check_eq("z_addr", 64'(z_wr_addr), (z_n < 2) ? 64'(z_n) : 64'(z_n - 2));
                check_eq("z_data", 64'(z_wr_data), 64'(16'h0700 + z_n));
                if (z_n == 2) check_eq("z_ch_done_mid", 64'(z_ch_done), 64'd3);
                z_n++;
            end
            z_in_data = 16'(16'h0700 + z_acc);
            if (z_in_ready) z_acc++;
        end
        z_in_valid = 1'b0;
        check_eq("z_wr_cnt", 64'(z_n), 64'd4);
        check_eq("z_done", 64'({z_done, z_busy, z_ch_done}), 64'b10111);

        // Default lengths: bank 0 completes after address 50703
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0; d_in_valid = 1'b1; d_in_data = 16'hbeef;
        d_n = 0; d_hit = 1'b0;
        for (int c = 0; c < 52000 && !d_hit; c++) begin
            @(negedge clk);
            if (d_wr_en) begin
                check_eq("d_addr", 64'({d_wr_sel, d_wr_addr}), 64'({3'b001, 16'(d_n)}));
                if (d_wr_addr == 16'd50703) begin
                    d_hit = 1'b1;
                    check_eq("d_ch_done_pre", 64'(d_ch_done), 64'd0);
                end
                d_n++;
            end
        end
        check_eq("d_last_seen", 64'(d_hit), 64'd1);
        @(negedge clk);
        check_eq("d_ch_done_post", 64'(d_ch_done), 64'd1);
        d_in_valid = 1'b0; d_abort = 1'b1;
        @(negedge clk); d_abort = 1'b0;
        @(negedge clk);
        check_eq("d_abort", 64'({d_busy, d_done, d_ch_done}), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
